bht_btb_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage miniRV pipeline. It replaces the fixed predict-not-taken policy, where npc comes from ID and a taken branch flushes IF/ID.
- IF looks up the fetch PC combinationally and gets a predicted-taken flag and target. The ID-stage branch/jump resolver writes back outcomes one per cycle.
- A direct-mapped table of tagged entries (valid, tag, target, saturating counter) plus two saturating performance counters.

---
 rtl/bht_btb_predictor_pkg.sv | 28 ++
 rtl/bht_btb_predictor_if.sv | 24 ++
 rtl/bht_btb_predictor_sat_ctr.sv | 12 +
 rtl/bht_btb_predictor.sv | 63 ++++++
 tb/tb_bht_btb_predictor.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/bht_btb_predictor_pkg.sv
// bp_pkg: shared predictor defaults, counter constants, entry layout and PC field extraction
package bp_pkg;
  localparam int DEF_XLEN = 32;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_TAG_W = 8;
  localparam int DEF_CNT_W = 2;
  typedef struct packed {
    logic valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0] target;
    logic [DEF_CNT_W-1:0] ctr;
  } entry_t;
  function automatic int ctr_max(int w);
    return (1 << w) - 1;
  endfunction
  function automatic int ctr_wt(int w);
    return 1 << (w - 1);
  endfunction
  function automatic int ctr_wnt(int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic logic [7:0] pc_idx(logic [63:0] pc, int idx_w);
    return 8'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
  endfunction
  function automatic logic [31:0] pc_tag(logic [63:0] pc, int idx_w, int tag_w);
    return 32'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
  endfunction
endpackage

// File: rtl/bht_btb_predictor_if.sv
// bht_btb_predictor_if: lookup (if_pc -> pred_*), resolve (upd_*) and perf (perf_*) bus; master drives requests, slave is the predictor
interface bht_btb_predictor_if #(parameter int XLEN = 32, parameter int PERF_W = 16);
  logic [XLEN-1:0] if_pc;
  logic pred_hit;
  logic pred_taken;
  logic [XLEN-1:0] pred_target;
  logic upd_en;
  logic [XLEN-1:0] upd_pc;
  logic upd_taken;
  logic upd_is_jump;
  logic [XLEN-1:0] upd_target;
  logic upd_mispred;
  logic perf_clr;
  logic [PERF_W-1:0] perf_br_cnt;
  logic [PERF_W-1:0] perf_miss_cnt;
  modport master (
    output if_pc, upd_en, upd_pc, upd_taken, upd_is_jump, upd_target, upd_mispred, perf_clr,
    input pred_hit, pred_taken, pred_target, perf_br_cnt, perf_miss_cnt
  );
  modport slave (
    input if_pc, upd_en, upd_pc, upd_taken, upd_is_jump, upd_target, upd_mispred, perf_clr,
    output pred_hit, pred_taken, pred_target, perf_br_cnt, perf_miss_cnt
  );
endinterface

// File: rtl/bht_btb_predictor_sat_ctr.sv
// sat_ctr: next value of a saturating direction counter; ports cur, up (else down), force_max -> nxt
module sat_ctr import bp_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             up,
  input  logic             force_max,
  output logic [CNT_W-1:0] nxt
);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(ctr_max(CNT_W));
  always_comb nxt = force_max ? C_MAX : up ? (cur == C_MAX ? cur : cur + 1'b1) : (cur == '0 ? cur : cur - 1'b1);
endmodule

// File: rtl/bht_btb_predictor.sv
// bht_btb_predictor: direct-mapped tagged BHT/BTB; ports clk, rst (async active-low), bus (lookup, resolve update, perf counters)
module bht_btb_predictor import bp_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PERF_W = 16
) (
  input logic clk,
  input logic rst,
  bht_btb_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(ctr_max(CNT_W));
  localparam logic [CNT_W-1:0] C_WT = CNT_W'(ctr_wt(CNT_W));
  localparam logic [CNT_W-1:0] C_WNT = CNT_W'(ctr_wnt(CNT_W));
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] target;
    logic [CNT_W-1:0] ctr;
  } ent_t;
  ent_t tbl [ENTRIES];
  ent_t l_e, u_e, new_e;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic u_hit;
  logic [CNT_W-1:0] u_ctr;
  logic [PERF_W-1:0] br_cnt, miss_cnt;
  always_comb begin
    l_idx = IDX_W'(pc_idx(64'(bus.if_pc), IDX_W));
    l_tag = TAG_W'(pc_tag(64'(bus.if_pc), IDX_W, TAG_W));
    l_e = tbl[l_idx];
    bus.pred_hit = l_e.valid && l_e.tag == l_tag;
    bus.pred_taken = bus.pred_hit && l_e.ctr[CNT_W-1];
    bus.pred_target = bus.pred_taken ? l_e.target : '0;
  end
  always_comb begin
    u_idx = IDX_W'(pc_idx(64'(bus.upd_pc), IDX_W));
    u_tag = TAG_W'(pc_tag(64'(bus.upd_pc), IDX_W, TAG_W));
    u_e = tbl[u_idx];
    u_hit = u_e.valid && u_e.tag == u_tag;
  end
  sat_ctr #(.CNT_W(CNT_W)) u_sat (.cur(u_e.ctr), .up(bus.upd_taken), .force_max(bus.upd_is_jump), .nxt(u_ctr));
  // a not-taken hit keeps its target so a later re-strengthening still redirects correctly
  always_comb new_e = u_hit
    ? '{valid: 1'b1, tag: u_tag, target: (bus.upd_taken || bus.upd_is_jump) ? bus.upd_target : u_e.target, ctr: u_ctr}
    : '{valid: 1'b1, tag: u_tag, target: bus.upd_target, ctr: bus.upd_is_jump ? C_MAX : C_WT};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: C_WNT};
      br_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      // a not-taken miss leaves the slot alone so an aliasing branch is not evicted
      if (bus.upd_en && (u_hit || bus.upd_taken || bus.upd_is_jump)) tbl[u_idx] <= new_e;
      br_cnt <= bus.perf_clr ? '0 : (bus.upd_en && br_cnt != '1) ? br_cnt + 1'b1 : br_cnt;
      miss_cnt <= bus.perf_clr ? '0 : (bus.upd_en && bus.upd_mispred && miss_cnt != '1) ? miss_cnt + 1'b1 : miss_cnt;
    end
  end
  assign bus.perf_br_cnt = br_cnt;
  assign bus.perf_miss_cnt = miss_cnt;
endmodule

// File: tb/tb_bht_btb_predictor.sv
// tb_bht_btb_predictor: directed and random stimulus scored against a behavioural predictor model
module tb_bht_btb_predictor;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bht_btb_predictor_if #(.XLEN(32), .PERF_W(PW)) bus ();
  bht_btb_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(8), .CNT_W(2), .PERF_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic hit;
    logic tkn;
    logic [31:0] tgt;
    int br;
    int miss;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit m_valid [16];
  int m_tag [16];
  logic [31:0] m_tgt [16];
  int m_ctr [16];
  int m_br, m_miss;
  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
      m_ctr[i] = 1;
    end
    m_br = 0;
    m_miss = 0;
  endtask
  function automatic exp_t m_look(logic [31:0] pc);
    exp_t e;
    int i = int'((pc >> 2) % 16);
    int t = int'((pc >> 6) % 256);
    e.hit = m_valid[i] && m_tag[i] == t;
    e.tkn = e.hit && m_ctr[i] >= 2;
    e.tgt = e.tkn ? m_tgt[i] : 32'h0;
    e.br = m_br;
    e.miss = m_miss;
    return e;
  endfunction
  task automatic m_update(logic en, logic [31:0] pc, logic tk, logic jp, logic [31:0] tg, logic mp, logic clr);
    int i = int'((pc >> 2) % 16);
    int t = int'((pc >> 6) % 256);
    if (en) begin
      if (m_valid[i] && m_tag[i] == t) begin
        if (jp) begin m_ctr[i] = 3; m_tgt[i] = tg; end
        else if (tk) begin m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = tg; end
        else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (tk || jp) begin
        m_valid[i] = 1;
        m_tag[i] = t;
        m_tgt[i] = tg;
        m_ctr[i] = jp ? 3 : 2;
      end
    end
    if (clr) begin
      m_br = 0;
      m_miss = 0;
    end else begin
      if (en && m_br < PMAX) m_br++;
      if (en && mp && m_miss < PMAX) m_miss++;
    end
  endtask
  task automatic step(logic [31:0] pc, logic en, logic [31:0] upc, logic tk, logic jp, logic [31:0] tg, logic mp, logic clr, logic r);
    @(posedge clk);
    #1;
    rst = r;
    bus.if_pc = pc;
    bus.upd_en = en;
    bus.upd_pc = upc;
    bus.upd_taken = tk;
    bus.upd_is_jump = jp;
    bus.upd_target = tg;
    bus.upd_mispred = mp;
    bus.perf_clr = clr;
    if (!r) m_reset();
    q.push_back(m_look(pc));
    if (r) m_update(en, upc, tk, jp, tg, mp, clr);
  endtask
  task automatic look(logic [31:0] pc);
    step(pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic upd(logic [31:0] pc, logic [31:0] upc, logic tk, logic jp, logic [31:0] tg, logic mp);
    step(pc, 1'b1, upc, tk, jp, tg, mp, 1'b0, 1'b1);
  endtask
  task automatic chk(string n, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, got, want, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pred_hit", 32'(bus.pred_hit), 32'(e.hit));
        chk("pred_taken", 32'(bus.pred_taken), 32'(e.tkn));
        chk("pred_target", bus.pred_target, e.tgt);
        chk("perf_br_cnt", 32'(bus.perf_br_cnt), 32'(e.br));
        chk("perf_miss_cnt", 32'(bus.perf_miss_cnt), 32'(e.miss));
      end
    end
  end
  initial begin
    logic [31:0] pc, upc;
    bus.if_pc = 0;
    bus.upd_en = 0;
    bus.upd_pc = 0;
    bus.upd_taken = 0;
    bus.upd_is_jump = 0;
    bus.upd_target = 0;
    bus.upd_mispred = 0;
    bus.perf_clr = 0;
    m_reset();
    step(32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 1'b0);
    step(32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a <= 32'h3C; a += 4) look(32'(a));
    upd(32'h40, 32'h40, 1'b1, 1'b0, 32'h10, 1'b0);
    look(32'h40);
    for (int k = 0; k < 3; k++) upd(32'h40, 32'h40, 1'b1, 1'b0, 32'h10, 1'b0);
    upd(32'h40, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    upd(32'h40, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    upd(32'h40, 32'h40, 1'b1, 1'b0, 32'h10, 1'b0);
    upd(32'h40, 32'h440, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h40);
    upd(32'h440, 32'h440, 1'b1, 1'b0, 32'h80, 1'b0);
    look(32'h440);
    look(32'h40);
    upd(32'h7C, 32'h7C, 1'b1, 1'b1, 32'h200, 1'b0);
    look(32'h7C);
    upd(32'h7C, 32'h7C, 1'b0, 1'b0, 32'h0, 1'b0);
    look(32'h7C);
    step(32'h7C, 1'b0, 32'h7C, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b1);
    look(32'h7C);
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) upd(32'h7C, 32'h100 + 32'(k * 4), 1'(k % 2), 1'b0, 32'h300, 1'(k < 2));
    look(32'h7C);
    step(32'h7C, 1'b1, 32'h7C, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 1'b1);
    look(32'h7C);
    step(32'h7C, 1'b1, 32'h7C, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    look(32'h7C);
    for (int k = 0; k < 3000; k++) begin
      pc = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      upc = ($urandom_range(0, 1) != 0) ? pc : 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      step(pc, 1'($urandom_range(0, 3) != 0), upc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 299) != 0));
    end
    look(32'h0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected responses never compared", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
